// File: rtl/shared_counter_arb.sv
// Round-robin shared fetch-and-add counter: each grant returns the pre-increment value.
// Define SHARED_CNT_TRACE_EN to compile simulation-only grant/wrap logging.
module shared_counter_arb #(
    parameter int unsigned      NUM_CH  = 4,
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      STEP    = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [WIDTH-1:0]  gnt_val,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  cnt,
    output logic              ovf
);

    localparam int unsigned      PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0]  gnt_val_q, gnt_val_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              win_vld;
    logic [PW-1:0]     win_idx;
    logic [PW:0]       scan;
    logic [WIDTH:0]    sum;
    logic              grant_ok;

    // Scan req starting at ptr_q, wrapping; the first set bit wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(i);
            if (scan >= (PW+1)'(NUM_CH))
                scan = scan - (PW+1)'(NUM_CH);
            if (!win_vld && req[scan[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan[PW-1:0];
            end
        end
    end

    assign sum      = {1'b0, cnt_q} + {1'b0, STEP_W};
    assign grant_ok = win_vld && !clr && !load;

    always_comb begin
        ptr_d     = ptr_q;
        gnt_d     = '0;
        gnt_val_d = gnt_val_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        if (clr) begin
            cnt_d = RST_VAL;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (grant_ok) begin
            gnt_d     = NUM_CH'(1) << win_idx;
            gnt_val_d = cnt_q;
            cnt_d     = sum[WIDTH-1:0];
            ovf_d     = ovf_q | sum[WIDTH];
            // With NUM_CH=1 the compare is always true, pinning ptr at 0.
            ptr_d     = (win_idx == PW'(NUM_CH-1)) ? '0 : PW'(win_idx + 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_val_q <= '0;
            cnt_q     <= RST_VAL;
            ovf_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_val_q <= gnt_val_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_val = gnt_val_q;
    assign cnt     = cnt_q;
    assign ovf     = ovf_q;

`ifdef SHARED_CNT_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_CH; i++)
                if (gnt_q[i]) $display("%m: ch %0d got %0d", i, gnt_val_q);
            if (ovf_d && !ovf_q) $display("%m: counter wrapped");
        end
    end
`endif

endmodule

// File: tb/tb_shared_counter_arb.sv
// Randomized bench for shared_counter_arb: STEP=1 and STEP=3 instances share stimulus
// and are compared every cycle against a ticket-dispenser reference model.
module tb_shared_counter_arb;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  req = '0;
    logic          clr = 1'b0, load = 1'b0;
    logic [31:0]   load_val = '0;

    logic [N-1:0]  gnt_a, gnt_b;
    logic [31:0]   gv_a, gv_b, cnt_a, cnt_b;
    logic          ovf_a, ovf_b;

    always #5 clk = ~clk;

    shared_counter_arb #(.NUM_CH(N), .WIDTH(32), .STEP(1), .RST_VAL(32'd0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a), .gnt_val(gv_a),
        .clr(clr), .load(load), .load_val(load_val), .cnt(cnt_a), .ovf(ovf_a));

    shared_counter_arb #(.NUM_CH(N), .WIDTH(32), .STEP(3), .RST_VAL(32'd0)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_b), .gnt_val(gv_b),
        .clr(clr), .load(load), .load_val(load_val), .cnt(cnt_b), .ovf(ovf_b));

    int errs = 0;
    int checks = 0;

    // Reference state: counter as unbounded integer reduced mod 2^32 per grant.
    longint unsigned m_cnt [2];
    bit              m_ovf [2];
    longint unsigned m_gv  [2];
    logic [N-1:0]    m_gnt;
    int              m_ptr;
    longint unsigned steps [2] = '{64'd1, 64'd3};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_ovf[d] = 0; m_gv[d] = 0;
        end
        m_gnt = '0;
        m_ptr = 0;
    endtask

    task automatic model_edge();
        int w;
        longint unsigned s;
        m_gnt = '0;
        if (clr) begin
            for (int d = 0; d < 2; d++) begin m_cnt[d] = 0; m_ovf[d] = 0; end
        end else if (load) begin
            for (int d = 0; d < 2; d++) m_cnt[d] = load_val;
        end else begin
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            if (w >= 0) begin
                m_gnt[w] = 1'b1;
                for (int d = 0; d < 2; d++) begin
                    m_gv[d] = m_cnt[d];
                    s = m_cnt[d] + steps[d];
                    if (s >= 64'h1_0000_0000) m_ovf[d] = 1;
                    m_cnt[d] = s % 64'h1_0000_0000;
                end
                m_ptr = (w + 1) % N;
            end
        end
    endtask

    task automatic check_all();
        chk("gnt_s1", 64'(gnt_a), 64'(m_gnt));
        chk("gnt_s3", 64'(gnt_b), 64'(m_gnt));
        chk("cnt_s1", 64'(cnt_a), m_cnt[0]);
        chk("cnt_s3", 64'(cnt_b), m_cnt[1]);
        chk("ovf_s1", 64'(ovf_a), 64'(m_ovf[0]));
        chk("ovf_s3", 64'(ovf_b), 64'(m_ovf[1]));
        if (m_gnt != '0) begin
            chk("gval_s1", 64'(gv_a), m_gv[0]);
            chk("gval_s3", 64'(gv_b), m_gv[1]);
        end
    endtask

    // Inputs applied at negedge, sampled at posedge, outputs checked at next negedge.
    task automatic step(input logic [N-1:0] r, input logic c, input logic l, input logic [31:0] lv);
        req = r; clr = c; load = l; load_val = lv;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    logic [N-1:0] pend;
    logic [31:0]  lv;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gnt", 64'(gnt_a), 64'd0);
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_gval", 64'(gv_a), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step('0, 1'b0, 1'b0, '0);

        // All four request together, each drops on its grant.
        pend = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step(pend, 1'b0, 1'b0, '0);
            chk("rr_order", 64'(gnt_a), 64'(1) << i);
            chk("rr_gval", 64'(gv_a), 64'(i));
            pend = pend & ~gnt_a;
        end
        step('0, 1'b0, 1'b0, '0);
        chk("rr_final_cnt", 64'(cnt_a), 64'd4);

        // ch2 alone for three edges on the STEP=3 instance.
        step('0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 1'b0, 1'b0, '0);
            chk("ch2_gval_s3", 64'(gv_b), 64'(3 * i));
        end
        step('0, 1'b0, 1'b0, '0);
        chk("ch2_cnt_s3", 64'(cnt_b), 64'd9);

        // Load beats grant, then grant wraps, then clr.
        step(4'b0001, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("load_nognt", 64'(gnt_a), 64'd0);
        chk("load_cnt", 64'(cnt_a), 64'hFFFF_FFFF);
        step(4'b0001, 1'b0, 1'b0, '0);
        chk("wrap_gval", 64'(gv_a), 64'hFFFF_FFFF);
        chk("wrap_cnt", 64'(cnt_a), 64'd0);
        chk("wrap_ovf", 64'(ovf_a), 64'd1);
        step('0, 1'b1, 1'b0, '0);
        chk("clr_ovf", 64'(ovf_a), 64'd0);

        // clr beats grant; request served next edge.
        step(4'b0010, 1'b1, 1'b0, '0);
        chk("clr_nognt", 64'(gnt_a), 64'd0);
        step(4'b0010, 1'b0, 1'b0, '0);
        chk("clr_then_gnt", 64'(gnt_a), 64'd2);
        chk("clr_then_gval", 64'(gv_a), 64'd0);
        step('0, 1'b0, 1'b0, '0);

        // Random traffic: granted channels usually drop, occasional withdraw/clr/load.
        pend = '0;
        for (int t = 0; t < 400; t++) begin
            pend = pend & ~(m_gnt & N'($urandom_range(0, 15) | 4'b1110 & N'($urandom)));
            if ($urandom_range(0, 9) == 0) pend = pend & N'($urandom);
            pend = pend | (N'($urandom) & N'($urandom));
            lv = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 6)) : 32'($urandom);
            step(pend, $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0, lv);
        end

        // Asynchronous reset while a grant is visible and ovf is set.
        step('0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step(4'b0001, 1'b0, 1'b0, '0);
        chk("pre_arst_gnt", 64'(gnt_a), 64'd1);
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_gnt", 64'(gnt_a), 64'd0);
        chk("arst_cnt", 64'(cnt_a), 64'd0);
        chk("arst_ovf", 64'(ovf_a), 64'd0);
        chk("arst_cnt_s3", 64'(cnt_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1000, 1'b0, 1'b0, '0);
        step('0, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
